pipe_hazard_ctrl: RTL and testbench

//  Parametrised stall/refresh controller for the in-order CPU pipeline. A scoreboard tracks pending

---
 rtl/pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/refresh controller with long-latency write scoreboard
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs_ren/id_rs     ID source rs read enable / index
//   id_rt_ren/id_rt     ID source rt read enable / index
//   id_branch           ID instruction resolves in ID (no EX bypass)
//   id_long/id_wreg     ID instruction is a long-latency writer / its destination
//   md_start, md_done   multi-cycle mul/div launch pulse and completion
//   exc_oc              exception/eret committed in MEM
//   stall[NSTG-2:0]     hold pipeline register k
//   refresh[NSTG-2:0]   load a bubble into pipeline register k
//   md_kill             abort in-flight mul/div
//   perf_stall_cyc      (PIPE_HAZARD_PERF_EN only) saturating count of stall[0] cycles
//   perf_flush_cnt      (PIPE_HAZARD_PERF_EN only) saturating count of exc_oc events
//
// Optional feature macro: PIPE_HAZARD_PERF_EN
module pipe_hazard_ctrl #(
    parameter int NSTG      = 5,
    parameter int SB_DEPTH  = 4,
    parameter int LOAD_LAT  = 2,
    parameter int FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_rs_ren,
    input  logic [4:0]      id_rs,
    input  logic            id_rt_ren,
    input  logic [4:0]      id_rt,
    input  logic            id_branch,
    input  logic            id_long,
    input  logic [4:0]      id_wreg,
    input  logic            md_start,
    input  logic            md_done,
    input  logic            exc_oc,
    output logic [NSTG-2:0] stall,
    output logic [NSTG-2:0] refresh,
    output logic            md_kill
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [15:0]     perf_flush_cnt
`endif
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int IW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    typedef enum logic [1:0] {RUN, MDWAIT, FLUSH} state_t;

    state_t          state, state_nx;
    logic [FW-1:0]   fl_cnt, fl_cnt_nx;
    logic [4:0]      sb_reg [SB_DEPTH];
    logic [CW-1:0]   sb_cnt [SB_DEPTH];

    logic            hit_rs, hit_rt, match, free;
    logic [IW-1:0]   match_idx, free_idx, tgt_idx;
    logic            raw, full, hazard, use_haz, issue;
    logic [NSTG-2:0] stall_c, refresh_c;
    logic            kill_c;

    // Scoreboard lookup. Descending scan so the lowest free index wins.
    always_comb begin
        hit_rs    = 1'b0;
        hit_rt    = 1'b0;
        match     = 1'b0;
        free      = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = SB_DEPTH - 1; i >= 0; i--) begin
            if (sb_cnt[i] == '0) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end else begin
                // Non-branch readers pick up the final count through the EX bypass.
                if (sb_reg[i] == id_rs && (id_branch || sb_cnt[i] > CW'(1)))
                    hit_rs = 1'b1;
                if (sb_reg[i] == id_rt && (id_branch || sb_cnt[i] > CW'(1)))
                    hit_rt = 1'b1;
                if (sb_reg[i] == id_wreg) begin
                    match     = 1'b1;
                    match_idx = IW'(i);
                end
            end
        end
    end

    assign raw     = id_valid & ((id_rs_ren & (id_rs != 5'd0) & hit_rs) |
                                 (id_rt_ren & (id_rt != 5'd0) & hit_rt));
    assign full    = id_valid & id_long & ~free & ~match;
    assign hazard  = raw | full;
    assign tgt_idx = match ? match_idx : free_idx;

    // Control FSM and stall/refresh vector generation.
    always_comb begin
        state_nx  = state;
        fl_cnt_nx = fl_cnt;
        stall_c   = '0;
        refresh_c = '0;
        kill_c    = 1'b0;
        use_haz   = 1'b0;
        case (state)
            RUN: begin
                if (exc_oc) begin
                    state_nx              = FLUSH;
                    fl_cnt_nx             = FW'(FLUSH_CYC);
                    refresh_c[NSTG-3:0]   = '1;
                    kill_c                = md_start;
                end else begin
                    use_haz = 1'b1;
                    if (md_start)
                        state_nx = MDWAIT;
                end
            end
            MDWAIT: begin
                if (exc_oc) begin
                    state_nx            = FLUSH;
                    fl_cnt_nx           = FW'(FLUSH_CYC);
                    refresh_c[NSTG-3:0] = '1;
                    kill_c              = 1'b1;
                end else if (md_done) begin
                    state_nx = RUN;
                    use_haz  = 1'b1;
                end else begin
                    stall_c[1:0] = 2'b11;
                    refresh_c[2] = 1'b1;
                end
            end
            FLUSH: begin
                refresh_c[0] = 1'b1;
                if (exc_oc) begin
                    refresh_c[NSTG-3:0] = '1;
                    fl_cnt_nx           = FW'(FLUSH_CYC);
                end else if (fl_cnt <= FW'(1)) begin
                    state_nx = RUN;
                end else begin
                    fl_cnt_nx = fl_cnt - FW'(1);
                end
            end
            default: state_nx = RUN;
        endcase
        if (use_haz && hazard) begin
            stall_c[0]   = 1'b1;
            refresh_c[1] = 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign stall   = reset ? '0 : (stall_c & ~refresh_c);
    assign refresh = reset ? '0 : refresh_c;
    assign md_kill = ~reset & kill_c;

    assign issue = id_valid & id_long & (id_wreg != 5'd0) & ~stall[0] & ~exc_oc &
                   (state != FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            fl_cnt <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_reg[i] <= '0;
                sb_cnt[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            fl_cnt <= fl_cnt_nx;
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (exc_oc) begin
                    sb_cnt[i] <= '0;
                end else if (issue && IW'(i) == tgt_idx) begin
                    sb_reg[i] <= id_wreg;
                    sb_cnt[i] <= CW'(LOAD_LAT);
                end else if (sb_cnt[i] != '0) begin
                    sb_cnt[i] <= sb_cnt[i] - CW'(1);
                end
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[0] && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (exc_oc && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_rs_ren, id_rt_ren, id_branch, id_long;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       md_start, md_done, exc_oc;

    logic [3:0] stall0, refresh0, stall1, refresh1;
    logic       md_kill0, md_kill1;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall0, perf_stall1;
    logic [15:0] perf_flush0, perf_flush1;
`endif

    int n_err = 0;
    int n_checks = 0;

    typedef struct {
        string      tag;
        bit         which;
        logic [3:0] st;
        logic [3:0] rf;
        logic       k;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_ren(id_rs_ren), .id_rs(id_rs), .id_rt_ren(id_rt_ren), .id_rt(id_rt),
        .id_branch(id_branch), .id_long(id_long), .id_wreg(id_wreg),
        .md_start(md_start), .md_done(md_done), .exc_oc(exc_oc),
        .stall(stall0), .refresh(refresh0), .md_kill(md_kill0)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall0), .perf_flush_cnt(perf_flush0)
`endif
    );

    pipe_hazard_ctrl #(.SB_DEPTH(1), .LOAD_LAT(4)) u_dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_ren(id_rs_ren), .id_rs(id_rs), .id_rt_ren(id_rt_ren), .id_rt(id_rt),
        .id_branch(id_branch), .id_long(id_long), .id_wreg(id_wreg),
        .md_start(md_start), .md_done(md_done), .exc_oc(exc_oc),
        .stall(stall1), .refresh(refresh1), .md_kill(md_kill1)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall1), .perf_flush_cnt(perf_flush1)
`endif
    );

    task automatic idle();
        id_valid = 0; id_rs_ren = 0; id_rs = 0; id_rt_ren = 0; id_rt = 0;
        id_branch = 0; id_long = 0; id_wreg = 0;
        md_start = 0; md_done = 0; exc_oc = 0;
    endtask

    task automatic lw(input logic [4:0] r);
        idle(); id_valid = 1; id_long = 1; id_wreg = r;
    endtask

    task automatic rd(input logic [4:0] r, input logic br);
        idle(); id_valid = 1; id_rs_ren = 1; id_rs = r; id_branch = br;
    endtask

    task automatic expect_out(input string tag, input bit which,
                              input logic [3:0] st, input logic [3:0] rf, input logic k);
        exp_t e;
        e.tag = tag; e.which = which; e.st = st; e.rf = rf; e.k = k;
        q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [8:0] obs, expv;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            obs  = e.which ? {stall1, refresh1, md_kill1} : {stall0, refresh0, md_kill0};
            expv = {e.st, e.rf, e.k};
            n_checks++;
            assert (obs === expv) else begin
                n_err++;
                $error("FAIL %s: observed stall/refresh/kill=%b expected=%b", e.tag, obs, expv);
            end
        end
    endtask

    task automatic tick();
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset holds all outputs low whatever the inputs say.
        idle(); id_valid = 1; md_start = 1; exc_oc = 1;
        expect_out("reset_dut0", 0, 4'b0, 4'b0, 0);
        expect_out("reset_dut1", 1, 4'b0, 4'b0, 0);
        tick();
        reset = 0;

        // Load-use: one bubble for a non-branch reader.
        lw(5);     expect_out("t1_issue", 0, 4'b0000, 4'b0000, 0); tick();
        rd(5, 0);  expect_out("t1_raw",   0, 4'b0001, 4'b0010, 0); tick();
        rd(5, 0);  expect_out("t1_go",    0, 4'b0000, 4'b0000, 0); tick();

        // Branch reader waits for count zero.
        lw(5);     expect_out("t2_issue", 0, 4'b0000, 4'b0000, 0); tick();
        rd(5, 1);  expect_out("t2_br_c2", 0, 4'b0001, 4'b0010, 0); tick();
        rd(5, 1);  expect_out("t2_br_c1", 0, 4'b0001, 4'b0010, 0); tick();
        rd(5, 1);  expect_out("t2_br_go", 0, 4'b0000, 4'b0000, 0); tick();

        // rt path and its read enable.
        lw(7);     tick();
        idle(); id_valid = 1; id_rt = 7;
        expect_out("rt_noren", 0, 4'b0000, 4'b0000, 0); tick();
        idle(); id_valid = 1; id_rt_ren = 1; id_rt = 7; id_branch = 1;
        expect_out("rt_br", 0, 4'b0001, 4'b0010, 0); tick();
        expect_out("rt_br_go", 0, 4'b0000, 4'b0000, 0); tick();

        // WAW reissue reloads the countdown.
        lw(6);     tick();
        lw(6);     expect_out("waw_reissue", 0, 4'b0000, 4'b0000, 0); tick();
        rd(6, 0);  expect_out("waw_raw",     0, 4'b0001, 4'b0010, 0); tick();
        rd(6, 0);  expect_out("waw_go",      0, 4'b0000, 4'b0000, 0); tick();

        // Mul/div freeze for six cycles, released on md_done.
        idle(); md_start = 1; expect_out("md_start", 0, 4'b0000, 4'b0000, 0); tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            expect_out("md_freeze", 0, 4'b0011, 4'b0100, 0); tick();
        end
        md_done = 1; expect_out("md_done", 0, 4'b0000, 4'b0000, 0); tick();
        idle();      expect_out("md_run",  0, 4'b0000, 4'b0000, 0); tick();

        // Exception during MDWAIT beats md_done; FLUSH ignores md_start.
        idle(); md_start = 1; tick();
        idle(); expect_out("md2_freeze", 0, 4'b0011, 4'b0100, 0); tick();
        exc_oc = 1; md_done = 1;
        expect_out("md_exc", 0, 4'b0000, 4'b0111, 1); tick();
        idle(); md_start = 1;
        expect_out("flush", 0, 4'b0000, 4'b0001, 0); tick();
        idle(); expect_out("flush_done", 0, 4'b0000, 4'b0000, 0); tick();

        // md_start and exc_oc together: kill, no MDWAIT.
        idle(); md_start = 1; exc_oc = 1;
        expect_out("start_exc", 0, 4'b0000, 4'b0111, 1); tick();
        idle(); expect_out("start_exc_flush", 0, 4'b0000, 4'b0001, 0); tick();
        idle(); expect_out("start_exc_run",   0, 4'b0000, 4'b0000, 0); tick();

        // Single-entry scoreboard, LOAD_LAT=4.
        reset = 1; idle(); tick(); reset = 0;
        lw(3); expect_out("sb1_issue", 1, 4'b0000, 4'b0000, 0); tick();
        lw(4);
        for (int i = 0; i < 4; i++) begin
            expect_out("sb1_full", 1, 4'b0001, 4'b0010, 0); tick();
        end
        expect_out("sb1_free", 1, 4'b0000, 4'b0000, 0); tick();
        idle(); id_valid = 1; id_rs_ren = 1; id_rt_ren = 1; id_branch = 1;
        expect_out("r0_reader", 1, 4'b0000, 4'b0000, 0); tick();
        idle(); tick(); tick(); tick();

        // Exception clears the scoreboard.
        lw(3); expect_out("sb1_reissue", 1, 4'b0000, 4'b0000, 0); tick();
        rd(3, 1); exc_oc = 1;
        expect_out("sb1_exc", 1, 4'b0000, 4'b0111, 0); tick();
        idle(); expect_out("sb1_flush", 1, 4'b0000, 4'b0001, 0); tick();
        rd(3, 1); expect_out("sb1_cleared", 1, 4'b0000, 4'b0000, 0); tick();

        // Reset in the middle of MDWAIT.
        idle(); tick();
        lw(5); md_start = 1; tick();
        idle(); expect_out("rst_pre_freeze", 0, 4'b0011, 4'b0100, 0); tick();
        reset = 1; rd(5, 1);
        expect_out("rst_mid", 0, 4'b0000, 4'b0000, 0);
        check_now();
        reset = 0;
        @(posedge clk); #1;
        rd(5, 1); expect_out("rst_sb_empty", 0, 4'b0000, 4'b0000, 0); tick();
        idle();   expect_out("rst_run",      0, 4'b0000, 4'b0000, 0); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
